// File: rtl/apb_master_bridge.sv
// APB3/APB4 initiator: accepts one command at a time from a valid/ready
// interface, runs it as an APB SETUP/ACCESS transfer toward slave 0 (UART)
// or slave 1 (GPIO) and returns a single-cycle response with read data or
// a timeout error flag.
//
// state  | meaning
// IDLE   | no transfer in flight, cmd_ready high
// SETUP  | psel asserted, pen low, command driven onto the bus
// ACCESS | pen high, waiting on PREADY or the timeout counter
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned SLV_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] padd,
  output logic [31:0] pdata,
  output logic        pwr,
  output logic        psel0,
  output logic        psel1,
  output logic        pen,
  output logic [3:0]  PSTRB,
  input  logic [31:0] prdata,
  input  logic        PREADY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] padd_q, padd_d;
  logic [31:0] pdata_q, pdata_d;
  logic        pwr_q, pwr_d;
  logic        psel0_q, psel0_d;
  logic        psel1_q, psel1_d;
  logic        pen_q, pen_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  // Saturating increment so the wait counter can never wrap back to zero.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Next-state and registered-output logic; bus outputs are loaded one edge
  // ahead so they are already valid in the state they belong to.
  always_comb begin
    state_d     = state_q;
    padd_d      = padd_q;
    pdata_d     = pdata_q;
    pwr_d       = pwr_q;
    psel0_d     = psel0_q;
    psel1_d     = psel1_q;
    pen_d       = pen_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          padd_d  = cmd_addr;
          pdata_d = cmd_wdata;
          pwr_d   = cmd_wr;
          psel0_d = ~cmd_addr[SLV_BIT];
          psel1_d = cmd_addr[SLV_BIT];
          pen_d   = 1'b0;
          pstrb_d = cmd_wr ? cmd_strb : 4'b0000;
          cnt_d   = 8'd0;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        pen_d   = 1'b1;
      end
      S_ACCESS: begin
        if (PREADY || (cnt_inc >= TIMEOUT_C)) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~PREADY;
          rsp_rdata_d = (PREADY && !pwr_q) ? prdata : 32'd0;
          psel0_d     = 1'b0;
          psel1_d     = 1'b0;
          pen_d       = 1'b0;
          pwr_d       = 1'b0;
          pstrb_d     = 4'b0000;
        end
        if (!PREADY) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        psel0_d = 1'b0;
        psel1_d = 1'b0;
        pen_d   = 1'b0;
        pwr_d   = 1'b0;
        pstrb_d = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset clears the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      padd_q      <= 32'd0;
      pdata_q     <= 32'd0;
      pwr_q       <= 1'b0;
      psel0_q     <= 1'b0;
      psel1_q     <= 1'b0;
      pen_q       <= 1'b0;
      pstrb_q     <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      padd_q      <= padd_d;
      pdata_q     <= pdata_d;
      pwr_q       <= pwr_d;
      psel0_q     <= psel0_d;
      psel1_q     <= psel1_d;
      pen_q       <= pen_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign padd      = padd_q;
  assign pdata     = pdata_q;
  assign pwr       = pwr_q;
  assign psel0     = psel0_q;
  assign psel1     = psel1_q;
  assign pen       = pen_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table of directed transfers with a simple
// wait-state slave, plus hand sequences for busy handling and async reset.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_strb = 4'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] padd;
  logic [31:0] pdata;
  logic        pwr;
  logic        psel0;
  logic        psel1;
  logic        pen;
  logic [3:0]  PSTRB;
  logic [31:0] prdata = 32'd0;
  logic        PREADY = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_bridge #(.TIMEOUT(4), .SLV_BIT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .padd(padd), .pdata(pdata), .pwr(pwr), .psel0(psel0), .psel1(psel1),
    .pen(pen), .PSTRB(PSTRB), .prdata(prdata), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;      // ACCESS cycles with PREADY low before it rises
    logic [31:0] prdata;
    logic [1:0]  exp_sel;    // {psel1, psel0}
    logic [3:0]  exp_strb;
    int          exp_lat;    // clock edges from accept to rsp_valid
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one transfer; inputs change and outputs are sampled on negedges.
  task automatic run_vec(input vec_t v);
    int  cyc;
    int  pen_cycles;
    bit  bus_bad;
    bit  done;
    @(negedge clk);
    check({v.name, " ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    PREADY    = 1'b0;
    prdata    = 32'hBAD0BAD0;
    pen_cycles = 0;
    bus_bad    = 1'b0;
    done       = 1'b0;
    for (cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        done = 1'b1;
        check({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
        check({v.name, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        check({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({v.name, " idle bus"}, {26'd0, psel1, psel0, pen, pwr, |PSTRB, cmd_ready}, 32'd1);
        check({v.name, " pen cycles"}, 32'(pen_cycles), 32'(v.exp_lat - 2));
        check({v.name, " bus stable"}, 32'(bus_bad), 32'd0);
        PREADY = 1'b0;
      end else begin
        if (cyc == 1) begin
          check({v.name, " setup pen/ready"}, {30'd0, pen, cmd_ready}, 32'd0);
          check({v.name, " setup padd"}, padd, v.addr);
          check({v.name, " setup pdata/pwr"}, pdata ^ 32'(pwr), v.wdata ^ 32'(v.wr));
        end
        if (pen) pen_cycles++;
        if ({psel1, psel0} !== v.exp_sel || PSTRB !== v.exp_strb ||
            padd !== v.addr || pwr !== v.wr || (cyc >= 2 && pen !== 1'b1))
          bus_bad = 1'b1;
        PREADY = (cyc >= 2) && ((cyc - 2) >= v.waits);
        prdata = PREADY ? v.prdata : 32'hBAD0BAD0;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s rsp_valid: got none within 40 cycles expected one", v.name);
      return;
    end
    @(negedge clk);
    check({v.name, " rsp one-cycle"}, {30'd0, rsp_valid, rsp_err}, 32'd0);
    check({v.name, " rdata hold"}, rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    vecs[0] = '{"wr_uart_0w", 1'b1, 32'h0000_0000, 32'h0000_00A5, 4'b0001, 0,   32'h0,         2'b01, 4'b0001, 3, 1'b0, 32'h0};
    vecs[1] = '{"rd_gpio_2w", 1'b0, 32'h0000_0101, 32'h1111_1111, 4'b1111, 2,   32'h0000_003C, 2'b10, 4'b0000, 5, 1'b0, 32'h0000_003C};
    vecs[2] = '{"rd_timeout", 1'b0, 32'h0000_0004, 32'h0,         4'b0000, 255, 32'hDEAD_BEEF, 2'b01, 4'b0000, 6, 1'b1, 32'h0};
    vecs[3] = '{"rd_boundary",1'b0, 32'h0000_01F0, 32'h0,         4'b0000, 3,   32'h1234_5678, 2'b10, 4'b0000, 6, 1'b0, 32'h1234_5678};
    vecs[4] = '{"wr_gpio_1w", 1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b1010, 1,   32'hFFFF_FFFF, 2'b10, 4'b1010, 4, 1'b0, 32'h0};
    vecs[5] = '{"wr_timeout", 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'b1111, 255, 32'h0,         2'b01, 4'b1111, 6, 1'b1, 32'h0};
    vecs[6] = '{"rd_uart_0w", 1'b0, 32'h0000_00FF, 32'h0,         4'b0110, 0,   32'hCAFE_0001, 2'b01, 4'b0000, 3, 1'b0, 32'hCAFE_0001};

    // Reset state
    #12;
    check("reset outputs", {25'd0, psel1, psel0, pen, pwr, |PSTRB, rsp_valid, rsp_err}, 32'd0);
    check("reset rdata/padd", rsp_rdata | padd | pdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready after reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Busy handling: cmd_valid stays high with a changing address
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_0104; PREADY = 1'b1;
    prdata = 32'h0000_0077;
    @(negedge clk);
    check("busy setup padd", padd, 32'h0000_0104);
    check("busy setup psel1", {30'd0, psel1, psel0}, 32'd2);
    cmd_addr = 32'h0000_02AA;
    @(negedge clk);
    check("busy access padd", padd, 32'h0000_0104);
    check("busy access pen", {30'd0, pen, cmd_ready}, 32'd2);
    cmd_addr = 32'h0000_00C0;
    @(negedge clk);
    check("busy rsp", {29'd0, rsp_valid, rsp_err, cmd_ready}, 32'd5);
    check("busy rdata", rsp_rdata, 32'h0000_0077);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy second padd", padd, 32'h0000_00C0);
    check("busy second psel0", {29'd0, psel1, psel0, pen}, 32'd2);
    seen = 1'b0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("busy second done", 32'(seen), 32'd1);

    // Async reset during ACCESS
    @(negedge clk);
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_0010; cmd_strb = 4'b1100;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst pre access", {30'd0, pen, psel0}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("rst async drop", {27'd0, psel0, psel1, pen, |PSTRB, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid || !cmd_ready || pen || psel0) seen = 1'b1;
    end
    check("rst idle no rsp", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

endmodule
